rom_share_arbiter: RTL and testbench
====================================

# rom_share_arbiter

Round-robin arbiter that time-shares one single-port image/palette ROM read port among several pixel-pipeline requesters (background tables, player sprites, item sprites). Each requester holds an address until granted. The arbiter drives the shared ROM address, tracks which requester owns each in-flight read through a tag pipeline matched to the ROM latency, and returns the data with a one-hot valid to the owner. It sits between the sprite/background renderers and the shared block-ROM instances, and runs on the pixel clock.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 17, ROM address width
- DATA_WIDTH, 8, ROM data width
- ROM_LATENCY, 2, ROM cycles from address-sampling edge to valid data (1..4)

- pixel_clk_in  input  1  pixel clock; all state on rising edge
- rst_n_in  input  1  reset; one clock, asynchronous, active-low
- enable_in  input  1  1 = new grants allowed; 0 = no new grants, in-flight reads still complete
- req_in  input  NUM_REQ  per-requester read request, level, held until granted
- addr_in  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- grant_out  output  NUM_REQ  one-hot, registered, one-cycle pulse per accepted request
- rom_addr_out  output  ADDR_WIDTH  registered address to the shared ROM
- rom_data_in  input  DATA_WIDTH  shared ROM read data
- data_out  output  DATA_WIDTH  registered returned data
- data_valid_out  output  NUM_REQ  one-hot, registered; marks the owner of data_out
- busy_out  output  1  1 while any read is in flight or granted

## Operation
- Eligible set = req_in & ~grant_out. A requester granted this cycle cannot win at the next edge. This gives it one cycle to drop or change its request, so a held request is never granted twice.
- At each edge with enable_in=1 and a non-empty eligible set, pick the winner W. W is the first eligible index searching upward from ptr, wrapping from NUM_REQ-1 to 0.
- On a grant: grant_out <= onehot(W), rom_addr_out <= addr_in[W], ptr <= (W+1) mod NUM_REQ, push tag onehot(W) into the tag pipeline.
- With no grant: grant_out <= 0, rom_addr_out holds its value, ptr holds, push tag 0.
- Tag pipeline depth = ROM_LATENCY+1. The tag pushed at edge E emerges at edge E+ROM_LATENCY+1. At that edge: data_valid_out <= tag, and data_out <= rom_data_in if tag≠0, else data_out holds.
- busy_out = OR of grant_out and all tag-pipeline stages (combinational from registers).
- When enable_in falls, in-flight reads still return. When enable_in rises, arbitration resumes from the saved ptr.
- Requester i must hold req_in[i] and its addr_in slice stable until it sees grant_out[i]=1.
- In the grant cycle the requester may present its next address with req held high. It becomes eligible again one edge later.

## Timing
- Reset (rst_n_in=0, asynchronous): grant_out=0, rom_addr_out=0, data_out=0, data_valid_out=0, busy_out=0, ptr=0, all tags cleared.
- Reset mid-operation: in-flight reads are discarded. No data_valid_out pulse may follow reset release unless a new grant produces it.
- Request-to-grant: request sampled at edge E, grant_out and rom_addr_out valid for the cycle after E.
- Grant-to-data: data_valid_out is high exactly ROM_LATENCY+1 cycles after grant_out, for one cycle.
- Throughput: one grant per cycle with two or more active requesters. A single continuously requesting requester is granted at most every other cycle.
- Order: data returns in grant order. Grants and returns may overlap in the same cycle.
- Simultaneous requests: resolved by round-robin from ptr only; there is no fixed priority.
- Simultaneous enable_in=0 and requests: no grant; ptr unchanged.

## Test plan
- Reset: assert rst_n_in mid-burst with tags in flight -> all outputs 0 immediately; no data_valid_out after release; first grant after release goes to the lowest requesting index.
- Single requester: req_in=4'b0001, addr 0x00123 held, ROM model of latency 2 returns addr[7:0] -> grant_out=0001 in cycle 1, rom_addr_out=0x00123, data_valid_out=0001 with data_out=0x23 in cycle 4; with req held, grants occur in cycles 1, 3, 5.
- Round-robin fairness: all four requesting continuously -> grant sequence 0,1,2,3,0,1,…; one grant per cycle; each requester gets exactly 25 of 100 grants.
- Pointer wrap: ptr=3, req_in=4'b1001 -> grant 3 then 0, not 0 then 3.
- Enable gating: drop enable_in with 3 reads in flight -> no new grant_out; all 3 data_valid_out pulses still arrive in order; busy_out falls the cycle after the last pulse.
- Latency sweep: ROM_LATENCY=1 and 4 under random requests -> every grant returns exactly one data_valid_out ROM_LATENCY+1 cycles later, to the correct owner, with the correct data.

Source files
------------

// File: rtl/rom_share_arbiter_if.sv
// rtl/rom_share_arbiter_if.sv - requester/ROM bundle between pixel pipeline and shared ROM arbiter
interface rom_share_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8
);
    logic                          enable_in;
    logic [NUM_REQ-1:0]            req_in;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_in;
    logic [NUM_REQ-1:0]            grant_out;
    logic [ADDR_WIDTH-1:0]         rom_addr_out;
    logic [DATA_WIDTH-1:0]         rom_data_in;
    logic [DATA_WIDTH-1:0]         data_out;
    logic [NUM_REQ-1:0]            data_valid_out;
    logic                          busy_out;

    modport master (
        output enable_in, req_in, addr_in, rom_data_in,
        input  grant_out, rom_addr_out, data_out, data_valid_out, busy_out
    );

    modport slave (
        input  enable_in, req_in, addr_in, rom_data_in,
        output grant_out, rom_addr_out, data_out, data_valid_out, busy_out
    );
endinterface

// File: rtl/rom_share_arbiter.sv
// rtl/rom_share_arbiter.sv - round-robin sharing of one ROM read port with tagged data return
module rom_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 17,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 2
) (
    input logic                pixel_clk_in,
    input logic                rst_n_in,
    rom_share_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      r_ptr;
    logic [NUM_REQ-1:0]    r_grant;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [NUM_REQ-1:0]    r_tag [ROM_LATENCY];
    logic [NUM_REQ-1:0]    r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    logic [NUM_REQ-1:0]    w_elig;
    logic [PTR_W-1:0]      w_idx;
    logic [PTR_W-1:0]      w_win;
    logic                  w_found;
    logic                  w_fire;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic                  w_tag_any;

    // A requester granted last edge is masked so a held request is not granted twice.
    always_comb begin
        w_elig  = bus.req_in & ~r_grant;
        w_idx   = '0;
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_win_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win == PTR_W'(k)) begin
                w_win_addr = bus.addr_in[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        w_tag_any = 1'b0;
        for (int s = 0; s < ROM_LATENCY; s++) begin
            w_tag_any = w_tag_any | (|r_tag[s]);
        end
    end

    assign w_fire = bus.enable_in & w_found;

    // r_grant is tag stage 0; r_tag[0..ROM_LATENCY-1] are the following stages.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_rom_addr <= '0;
            r_valid    <= '0;
            r_data     <= '0;
            for (int s = 0; s < ROM_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_grant  <= '0;
            r_tag[0] <= r_grant;
            for (int s = 1; s < ROM_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            r_valid <= r_tag[ROM_LATENCY-1];
            if (|r_tag[ROM_LATENCY-1]) begin
                r_data <= bus.rom_data_in;
            end
            if (w_fire) begin
                r_grant    <= NUM_REQ'(1) << w_win;
                r_rom_addr <= w_win_addr;
                r_ptr      <= (w_win == PTR_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
            end
        end
    end

    assign bus.grant_out      = r_grant;
    assign bus.rom_addr_out   = r_rom_addr;
    assign bus.data_out       = r_data;
    assign bus.data_valid_out = r_valid;
    // The delivery cycle counts as in flight, so busy drops the cycle after the last pulse.
    assign bus.busy_out       = (|r_grant) | w_tag_any | (|r_valid);
endmodule

// File: tb/tb_rom_share_arbiter.sv
// tb/tb_rom_share_arbiter.sv - scoreboard bench for rom_share_arbiter
module tb_rom_share_arbiter;
    localparam int N   = 4;
    localparam int AW  = 17;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_share_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rom_share_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT)) dut (
        .pixel_clk_in(clk),
        .rst_n_in    (rst_n),
        .bus         (bus)
    );

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return a[7:0] ^ a[16:9];
    endfunction

    logic [DW-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_fn(bus.rom_addr_out);
        for (int s = 1; s < LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
    end
    assign bus.rom_data_in = rom_pipe[LAT-1];

    typedef struct { int cyc; int owner; logic [AW-1:0] addr; } gexp_t;
    typedef struct { int cyc; int owner; logic [DW-1:0] data; } dexp_t;
    gexp_t gq[$];
    dexp_t dq[$];
    bit    busy_exp[int];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // requester population and arbitration reference
    bit            act_r [N];
    logic [AW-1:0] raddr [N];
    int            m_ptr = 0;
    int            m_last = -1;
    logic [N-1:0]  allow = '0;
    int            p_req = 0;
    int            p_en = 100;
    bit            fix_addr = 0;

    task automatic step();
        int w;
        bit en;
        for (int i = 0; i < N; i++) begin
            if (i == m_last) act_r[i] = 0;
            if (!act_r[i] && allow[i] && ($urandom_range(99) < p_req)) begin
                act_r[i] = 1;
                raddr[i] = fix_addr ? AW'(17'h00123) : AW'($urandom);
            end
            bus.req_in[i] = act_r[i];
            bus.addr_in[i*AW +: AW] = raddr[i];
        end
        en = ($urandom_range(99) < p_en);
        bus.enable_in = en;
        w = -1;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && act_r[j] && j != m_last) w = j;
            end
        end
        if (w >= 0) begin
            gq.push_back('{cyc + 1, w, raddr[w]});
            dq.push_back('{cyc + LAT + 2, w, rom_fn(raddr[w])});
            for (int c = cyc + 1; c <= cyc + LAT + 2; c++) busy_exp[c] = 1;
            m_ptr = (w + 1) % N;
        end
        m_last = w;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_grant", bus.grant_out, 0);
        chk("rst_rom_addr", bus.rom_addr_out, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_valid", bus.data_valid_out, 0);
        chk("rst_busy", bus.busy_out, 0);
        bus.req_in = '0;
        bus.enable_in = 1'b0;
        gq.delete();
        dq.delete();
        busy_exp.delete();
        m_ptr = 0;
        m_last = -1;
        for (int i = 0; i < N; i++) act_r[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int    fair_cnt [N];
    int    fair_lo = -1000;
    gexp_t mg;
    dexp_t md;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst_n) begin
            if (bus.grant_out != '0) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", bus.grant_out, 0);
                end else begin
                    mg = gq.pop_front();
                    chk("grant_cycle", cyc, mg.cyc);
                    chk("grant_owner", bus.grant_out, N'(1) << mg.owner);
                    chk("rom_addr", bus.rom_addr_out, mg.addr);
                end
                if (cyc > fair_lo && cyc <= fair_lo + 100)
                    for (int i = 0; i < N; i++) if (bus.grant_out[i]) fair_cnt[i]++;
            end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                mg = gq.pop_front();
                chk("grant_missing", bus.grant_out, N'(1) << mg.owner);
            end
            if (bus.data_valid_out != '0) begin
                if (dq.size() == 0) begin
                    chk("valid_unexpected", bus.data_valid_out, 0);
                end else begin
                    md = dq.pop_front();
                    chk("valid_cycle", cyc, md.cyc);
                    chk("valid_owner", bus.data_valid_out, N'(1) << md.owner);
                    chk("data", bus.data_out, md.data);
                end
            end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                md = dq.pop_front();
                chk("valid_missing", bus.data_valid_out, N'(1) << md.owner);
            end
            chk("busy", bus.busy_out, busy_exp.exists(cyc));
            busy_exp.delete(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.req_in = '0;
        bus.addr_in = '0;
        bus.enable_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            act_r[i] = 0;
            raddr[i] = '0;
            fair_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("init_grant", bus.grant_out, 0);
        chk("init_rom_addr", bus.rom_addr_out, 0);
        chk("init_data", bus.data_out, 0);
        chk("init_valid", bus.data_valid_out, 0);
        chk("init_busy", bus.busy_out, 0);
        rst_n = 1'b1;

        // single requester, fixed address, held continuously
        allow = 4'b0001; p_req = 100; p_en = 100; fix_addr = 1;
        repeat (8) step();
        fix_addr = 0; allow = '0;
        repeat (6) step();

        // all four requesting continuously: strict rotation
        allow = 4'b1111; p_req = 100;
        fair_lo = cyc;
        repeat (100) step();

        // enable dropped with reads in flight
        p_en = 0;
        repeat (10) step();
        for (int i = 0; i < N; i++) chk($sformatf("fair_count_%0d", i), fair_cnt[i], 25);
        p_en = 100;
        repeat (6) step();

        // pointer wrap: park ptr at 3, then requesters 0 and 3 together
        allow = '0;
        repeat (8) step();
        allow = 4'b0100;
        step();
        allow = '0;
        repeat (4) step();
        allow = 4'b1001;
        step();
        allow = '0;
        repeat (6) step();

        // random traffic
        allow = 4'b1111; p_req = 40; p_en = 80;
        repeat (300) step();

        // reset in the middle of a burst
        p_req = 100; p_en = 100;
        repeat (5) step();
        do_reset();
        allow = 4'b1010;
        repeat (4) step();
        allow = 4'b1111; p_req = 50; p_en = 75;
        repeat (200) step();

        allow = '0; p_en = 100;
        repeat (20) step();
        chk("grant_queue_drained", gq.size(), 0);
        chk("data_queue_drained", dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
